// File: rtl/fab_ccc_clken_gen.sv
// Multi-channel programmable clock-enable generator: NUM_CH dividers with staged, glitch-free divisor updates and a LOCK qualifier.
// Latency: all outputs registered; first CLKEN pulse DIV+1 edges after enable or reset release.
// Backpressure: none; DIV_LOAD strobes are always accepted and the last load before a terminal count wins.
module fab_ccc_clken_gen #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 5,
    parameter int DEFAULT_DIV = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                    FAB_CLK,
    input  logic                    FAB_RESET,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic [NUM_CH-1:0]       DIV_LOAD,
    input  logic [NUM_CH*DIV_W-1:0] DIV_IN,
    output logic [NUM_CH-1:0]       CLKEN,
    output logic [NUM_CH-1:0]       GL_DIV,
    output logic [NUM_CH-1:0]       PEND,
    output logic                    LOCK
);

    localparam int               LCW       = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_e;

    // Per-channel divider state
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic [DIV_W-1:0]  stg_q [NUM_CH];
    logic [DIV_W-1:0]  stg_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clken_q, clken_d;
    logic [NUM_CH-1:0] gl_q, gl_d;
    logic [NUM_CH-1:0] apply;

    // Lock tracking state
    lock_st_e          st_q, st_d;
    logic [LCW-1:0]    lcnt_q, lcnt_d;
    logic              lock_q, lock_d;

    // Divider next state: a staged divisor only takes effect at a period boundary (terminal count) or while disabled,
    // so a running period is never cut short. A load in the same cycle re-arms pend for the following boundary.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        stg_d   = stg_q;
        pend_d  = pend_q;
        clken_d = '0;
        gl_d    = gl_q;
        apply   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!CH_EN[i]) begin
                cnt_d[i] = '0;
                gl_d[i]  = 1'b0;
                apply[i] = pend_q[i];
            end else if (cnt_q[i] == div_q[i]) begin
                cnt_d[i]   = '0;
                clken_d[i] = 1'b1;
                gl_d[i]    = ~gl_q[i];
                apply[i]   = pend_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
            if (apply[i]) begin
                div_d[i]  = stg_q[i];
                pend_d[i] = 1'b0;
            end
            if (DIV_LOAD[i]) begin
                stg_d[i]  = DIV_IN[i*DIV_W +: DIV_W];
                pend_d[i] = 1'b1;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_RST;
                stg_q[i] <= DIV_RST;
            end
            pend_q  <= '0;
            clken_q <= '0;
            gl_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
                stg_q[i] <= stg_d[i];
            end
            pend_q  <= pend_d;
            clken_q <= clken_d;
            gl_q    <= gl_d;
        end
    end

    // Lock FSM next state: count consecutive quiet cycles (no load, nothing pending); any new load unlocks.
    always_comb begin
        st_d   = st_q;
        lcnt_d = lcnt_q;
        case (st_q)
            ST_WAIT: begin
                if ((|DIV_LOAD) || (|pend_q)) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LOCK_LAST) begin
                    st_d   = ST_LOCKED;
                    lcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_q + LCW'(1);
                end
            end
            ST_LOCKED: begin
                if (|DIV_LOAD) begin
                    st_d   = ST_WAIT;
                    lcnt_d = '0;
                end
            end
            default: begin
                st_d   = ST_WAIT;
                lcnt_d = '0;
            end
        endcase
        lock_d = (st_d == ST_LOCKED);
    end

    // Lock FSM registers
    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            st_q   <= ST_WAIT;
            lcnt_q <= '0;
            lock_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            lcnt_q <= lcnt_d;
            lock_q <= lock_d;
        end
    end

    assign CLKEN  = clken_q;
    assign GL_DIV = gl_q;
    assign PEND   = pend_q;
    assign LOCK   = lock_q;

endmodule

// File: tb/tb_fab_ccc_clken_gen.sv
// Self-checking bench for fab_ccc_clken_gen: cycle model feeds an expected-output queue, plus directed edge checks.
// Latency: expectations for each edge are queued before the edge and popped 1 time unit after it.
// Backpressure: not applicable; stimulus changes on the falling edge only.
module tb_fab_ccc_clken_gen;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 5;
    localparam int DEFAULT_DIV = 3;
    localparam int LOCK_CYCLES = 16;

    logic                    FAB_CLK = 1'b0;
    logic                    FAB_RESET;
    logic [NUM_CH-1:0]       CH_EN;
    logic [NUM_CH-1:0]       DIV_LOAD;
    logic [NUM_CH*DIV_W-1:0] DIV_IN;
    logic [NUM_CH-1:0]       CLKEN;
    logic [NUM_CH-1:0]       GL_DIV;
    logic [NUM_CH-1:0]       PEND;
    logic                    LOCK;

    fab_ccc_clken_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .CH_EN(CH_EN), .DIV_LOAD(DIV_LOAD),
        .DIV_IN(DIV_IN), .CLKEN(CLKEN), .GL_DIV(GL_DIV), .PEND(PEND), .LOCK(LOCK)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct packed {
        logic [NUM_CH-1:0] clken;
        logic [NUM_CH-1:0] gl;
        logic [NUM_CH-1:0] pend;
        logic              lock;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   edge_n = 0;

    // Reference model state
    int                m_cnt [NUM_CH];
    int                m_div [NUM_CH];
    int                m_stg [NUM_CH];
    logic [NUM_CH-1:0] m_pend, m_clken, m_gl;
    logic              m_lock;
    int                m_quiet;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0;
            m_div[c] = DEFAULT_DIV;
            m_stg[c] = DEFAULT_DIV;
        end
        m_pend  = '0;
        m_clken = '0;
        m_gl    = '0;
        m_lock  = 1'b0;
        m_quiet = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic quiet;
        logic take;
        quiet = !((|DIV_LOAD) || (|m_pend));
        if (!m_lock) begin
            if (!quiet) m_quiet = 0;
            else if (m_quiet == LOCK_CYCLES - 1) begin
                m_lock  = 1'b1;
                m_quiet = 0;
            end else m_quiet++;
        end else if (|DIV_LOAD) begin
            m_lock  = 1'b0;
            m_quiet = 0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            take = 1'b0;
            if (!CH_EN[c]) begin
                take       = m_pend[c];
                m_cnt[c]   = 0;
                m_clken[c] = 1'b0;
                m_gl[c]    = 1'b0;
            end else if (m_cnt[c] == m_div[c]) begin
                take       = m_pend[c];
                m_cnt[c]   = 0;
                m_clken[c] = 1'b1;
                m_gl[c]    = ~m_gl[c];
            end else begin
                m_cnt[c]   = m_cnt[c] + 1;
                m_clken[c] = 1'b0;
            end
            if (take) begin
                m_div[c]  = m_stg[c];
                m_pend[c] = 1'b0;
            end
            if (DIV_LOAD[c]) begin
                m_stg[c]  = int'(DIV_IN[c*DIV_W +: DIV_W]);
                m_pend[c] = 1'b1;
            end
        end
    endtask

    // One clock: queue the model's expectation, take the edge, pop and compare, return on the falling edge.
    task automatic tick();
        exp_t e;
        exp_t got;
        model_step();
        e.clken = m_clken;
        e.gl    = m_gl;
        e.pend  = m_pend;
        e.lock  = m_lock;
        sb_q.push_back(e);
        @(posedge FAB_CLK);
        #1;
        edge_n++;
        got = sb_q.pop_front();
        check("sb_clken", 32'(CLKEN), 32'(got.clken));
        check("sb_gl_div", 32'(GL_DIV), 32'(got.gl));
        check("sb_pend", 32'(PEND), 32'(got.pend));
        check("sb_lock", 32'(LOCK), 32'(got.lock));
        @(negedge FAB_CLK);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic load(input int ch, input int val);
        DIV_LOAD                  = NUM_CH'(1) << ch;
        DIV_IN[ch*DIV_W +: DIV_W] = DIV_W'(val);
    endtask

    initial begin
        FAB_RESET = 1'b1;
        CH_EN     = '1;
        DIV_LOAD  = '0;
        DIV_IN    = '0;
        model_reset();
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        check("rst_clken", 32'(CLKEN), 0);
        check("rst_gl_div", 32'(GL_DIV), 0);
        check("rst_pend", 32'(PEND), 0);
        check("rst_lock", 32'(LOCK), 0);
        FAB_RESET = 1'b0;

        // Defaults: pulses after edges 4, 8, 12; LOCK after edge 16
        run_to(3);  check("def_no_pulse3", 32'(CLKEN), 0);
        tick();     check("def_pulse4", 32'(CLKEN), 32'b111);
        run_to(8);  check("def_pulse8", 32'(CLKEN), 32'b111);
        run_to(12); check("def_pulse12", 32'(CLKEN), 32'b111);
        run_to(15); check("def_lock15", 32'(LOCK), 0);
        tick();     check("def_lock16", 32'(LOCK), 1);

        // Ch0 load DIV=1 with cnt=1: applies at the edge-20 terminal count
        run_to(17);
        load(0, 1);
        tick();     DIV_LOAD = '0;
        check("ch0_lock_drop", 32'(LOCK), 0);
        check("ch0_pend_set", 32'(PEND[0]), 1);
        run_to(19); check("ch0_no_early", 32'(CLKEN[0]), 0);
        tick();     check("ch0_tc_old", 32'(CLKEN[0]), 1);
        check("ch0_pend_clr", 32'(PEND[0]), 0);
        tick();     check("ch0_gap21", 32'(CLKEN[0]), 0);
        tick();     check("ch0_div2_22", 32'(CLKEN[0]), 1);
        run_to(35); check("ch0_lock35", 32'(LOCK), 0);
        tick();     check("ch0_lock36", 32'(LOCK), 1);

        // Ch1 load DIV=0 on its terminal-count cycle
        run_to(43);
        load(1, 0);
        tick();     DIV_LOAD = '0;
        check("ch1_tc44", 32'(CLKEN[1]), 1);
        check("ch1_pend44", 32'(PEND[1]), 1);
        tick();     check("ch1_gap45", 32'(CLKEN[1]), 0);
        run_to(47); check("ch1_gap47", 32'(CLKEN[1]), 0);
        tick();     check("ch1_tc48", 32'(CLKEN[1]), 1);
        check("ch1_pend48", 32'(PEND[1]), 0);
        tick();     check("ch1_hold49", 32'(CLKEN[1]), 1);
        run_to(52); check("ch1_hold52", 32'(CLKEN[1]), 1);

        // Ch2: two loads (7 then 5) before the terminal count, only 5 applies
        load(2, 7);
        tick();
        load(2, 5);
        tick();     DIV_LOAD = '0;
        check("ch2_pend54", 32'(PEND[2]), 1);
        run_to(56); check("ch2_tc56", 32'(CLKEN[2]), 1);
        check("ch2_pend56", 32'(PEND[2]), 0);
        run_to(61); check("ch2_gap61", 32'(CLKEN[2]), 0);
        tick();     check("ch2_div6_62", 32'(CLKEN[2]), 1);
        run_to(64); check("ch2_not_div8", 32'(CLKEN[2]), 0);
        run_to(68); check("ch2_div6_68", 32'(CLKEN[2]), 1);

        // Ch0 disabled while a load is pending: divisor applies at once
        load(0, 2);
        tick();     DIV_LOAD = '0;
        check("ch0_pend69", 32'(PEND[0]), 1);
        CH_EN = 3'b110;
        tick();
        check("ch0_dis_pend", 32'(PEND[0]), 0);
        check("ch0_dis_clken", 32'(CLKEN[0]), 0);
        check("ch0_dis_gl", 32'(GL_DIV[0]), 0);
        tick();
        CH_EN = 3'b111;
        run_to(73); check("ch0_reen73", 32'(CLKEN[0]), 0);
        tick();     check("ch0_reen74", 32'(CLKEN[0]), 1);
        run_to(77); check("ch0_reen77", 32'(CLKEN[0]), 1);

        // Reset while a divide-by-32 load is pending
        load(0, 31);
        tick();     DIV_LOAD = '0;
        check("rst2_pend_before", 32'(PEND[0]), 1);
        FAB_RESET = 1'b1;
        #1;
        check("rst2_clken", 32'(CLKEN), 0);
        check("rst2_gl_div", 32'(GL_DIV), 0);
        check("rst2_pend", 32'(PEND), 0);
        check("rst2_lock", 32'(LOCK), 0);
        model_reset();
        sb_q.delete();
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        FAB_RESET = 1'b0;
        edge_n    = 0;
        run_to(3);  check("rst2_gap3", 32'(CLKEN[0]), 0);
        tick();     check("rst2_pulse4", 32'(CLKEN[0]), 1);
        run_to(8);  check("rst2_pulse8", 32'(CLKEN[0]), 1);
        run_to(16); check("rst2_lock16", 32'(LOCK), 1);
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fab_ccc_clken_gen.md
# fab_ccc_clken_gen

Multi-channel programmable clock-enable generator for the fabric side of the MSS clock tree. It runs on the single fabric clock, FAB_CLK, and derives NUM_CH independently divided enable strobes plus toggle clocks. It generalises the fixed-divider bypass CCC configuration to run-time divisors, per-channel enables and glitch-free divisor changes. A LOCK indication gates downstream logic until every divider has been stable for LOCK_CYCLES cycles.

## Interface
- NUM_CH, 3 — number of output channels (A/B/C).
- DIV_W, 5 — divisor field width; divide ratio = DIV+1 (1..2^DIV_W).
- DEFAULT_DIV, 3 — divisor loaded into every channel at reset (÷4).
- LOCK_CYCLES, 16 — stable cycles required before LOCK asserts (≥2).
- FAB_CLK  in  1 — fabric clock; all logic on rising edge.
- FAB_RESET  in  1 — asynchronous, active-high reset.
- CH_EN  in  NUM_CH — per-channel run enable (level).
- DIV_LOAD  in  NUM_CH — one-cycle strobe: stage DIV_IN slice i for channel i.
- DIV_IN  in  NUM_CH*DIV_W — channel i divisor at bits [i*DIV_W +: DIV_W].
- CLKEN  out  NUM_CH — one-cycle enable pulse per divided period.
- GL_DIV  out  NUM_CH — divided clock, 50% duty, period 2*(DIV+1).
- PEND  out  NUM_CH — staged divisor not yet applied.
- LOCK  out  1 — all dividers stable.

## Operation
- Per channel: counter cnt (DIV_W), active divisor div, staged stg, flag pend.
- Reset values: cnt=0, div=DEFAULT_DIV, stg=DEFAULT_DIV, pend=0, CLKEN=0, GL_DIV=0, PEND=0, LOCK=0, lock FSM=WAIT, lock_cnt=0.
- CH_EN[i]=0: cnt←0, CLKEN[i]←0, GL_DIV[i]←0; if pend, div←stg and pend←0 immediately.
- CH_EN[i]=1, cnt==div (terminal count): cnt←0, CLKEN[i]←1, GL_DIV[i]←~GL_DIV[i]; if pend (value at start of cycle), div←stg and pend←0.
- CH_EN[i]=1, cnt≠div: cnt←cnt+1, CLKEN[i]←0.
- div=0: CLKEN[i] stays high every cycle; GL_DIV[i] toggles every cycle (FAB_CLK/2).
- DIV_LOAD[i]: stg←DIV_IN slice, pend←1. A load coincident with terminal count does not affect that terminal count; it applies at the next one. A load while pend=1 overwrites stg (last wins). A load of a value equal to div still sets pend and restarts lock.
- New divisor never truncates the running period: no CLKEN pulse spacing shorter than min(old, new)+1 cycles.
- Lock FSM, two states:
  - WAIT: if any DIV_LOAD or any pend is set this cycle, lock_cnt←0; else lock_cnt←lock_cnt+1. When lock_cnt==LOCK_CYCLES-1 and there is no load/pend, go to LOCKED, LOCK←1.
  - LOCKED: any DIV_LOAD bit → WAIT, LOCK←0, lock_cnt←0.
- CH_EN changes do not affect LOCK.
- FAB_RESET asserted mid-operation: all state returns to reset values asynchronously; the staged divisor is discarded.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- After reset release with CH_EN=1: first CLKEN pulse after rising edge DEFAULT_DIV+1, then every DIV+1 cycles.
- CH_EN 0→1: first CLKEN DIV+1 edges later (cnt starts from 0).
- PEND rises the edge after DIV_LOAD and falls on the edge that applies the divisor.
- LOCK rises after edge LOCK_CYCLES following reset release or the last pend clear. It falls on the edge after any DIV_LOAD.

## Test plan
- Reset, CH_EN=3'b111, defaults: CLKEN pulses after edges 4, 8, 12; GL_DIV period 8 cycles; LOCK=1 after edge 16; every output is 0 during reset.
- Ch0 load DIV=1 mid-period (cnt=1, div=3): edges at cnt 2 and 3 continue; terminal count applies the new divisor; PEND clears; pulses then every 2 cycles; LOCK drops the next edge and returns 16 cycles after PEND clears.
- Ch1 load DIV=0 on its terminal-count cycle: that pulse uses div=3; one more ÷4 period follows, then CLKEN[1] is held high continuously.
- Two loads to ch2 (7 then 5) before terminal count: only 5 applies (÷6); 7 is never observed.
- CH_EN[0]=0 with pend set: div is applied immediately, CLKEN[0]=GL_DIV[0]=0; re-enable gives the first pulse after new DIV+1 edges.
- Assert FAB_RESET during a pending load at DIV_W max (31): all outputs 0, div=3 after release, no ÷32 period seen.
